// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: serial line in, received byte and status out.
// master drives uart_rx and observes the results; slave is the receiver.
interface uart_byte_rx_if;
  logic       uart_rx;
  logic [7:0] uart_byte;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;
  modport master (output uart_rx, input uart_byte, byte_valid, frame_err, busy);
  modport slave (input uart_rx, output uart_byte, byte_valid, frame_err, busy);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with mid-bit sampling, frame error and break handling.
// Ports: clk, rst (sync, active-high); rx_if.slave carries uart_rx in and
// uart_byte, byte_valid, frame_err, busy out.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input logic           clk,
  input logic           rst,
  uart_byte_rx_if.slave rx_if
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q, settle_q;
  logic          rx_s, expire, arm_q, arm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, byte_q, byte_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  assign rx_s   = sync_q[1];
  assign expire = cnt_q == CW'(1);
  // The synchronizer resets to 1, so rx_s only reflects the line once settle_q
  // fills; arm_q then demands a real high before any start bit is accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    arm_d   = arm_q | (settle_q[1] & rx_s);
    case (state_q)
      IDLE: if (arm_q && !rx_s) begin
        state_d = START;
        cnt_d   = HALF;
      end
      START: if (expire) begin
        state_d = rx_s ? IDLE : DATA;
        cnt_d   = FULL;
        idx_d   = 3'd0;
      end
      DATA: if (expire) begin
        shift_d = {rx_s, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        cnt_d   = FULL;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (expire) begin
        state_d = rx_s ? IDLE : WAIT_HIGH;
        valid_d = rx_s;
        ferr_d  = !rx_s;
        byte_d  = rx_s ? shift_q : byte_q;
      end
      WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= 2'b11;
      settle_q <= 2'b00;
      arm_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], rx_if.uart_rx};
      settle_q <= {settle_q[0], 1'b1};
      arm_q    <= arm_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end
  assign rx_if.uart_byte  = byte_q;
  assign rx_if.byte_valid = valid_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed and random 8N1 frames checked against a queue-based reference.
module tb_uart_byte_rx;
  localparam int C   = 16;
  localparam int LAT = 2 + C / 2 + 9 * C;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int nv = 0, nf = 0, both = 0, dbl = 0, bcnt = 0, fall_cyc = 0, last_valid_cyc = 0;
  logic prev_v = 1'b0, prev_f = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_byte;
  uart_byte_rx_if bus();
  uart_byte_rx #(.CLKS_PER_BIT(C)) dut (.clk(clk), .rst(rst), .rx_if(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.byte_valid) begin
      nv++;
      last_valid_cyc = cyc;
      got.push_back(bus.uart_byte);
    end
    if (bus.frame_err) nf++;
    if (bus.byte_valid && bus.frame_err) both++;
    if ((bus.byte_valid && prev_v) || (bus.frame_err && prev_f)) dbl++;
    if (bus.busy) bcnt++;
    prev_v = bus.byte_valid;
    prev_f = bus.frame_err;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop_v, input int rst_bit);
    logic [9:0] f;
    f = {stop_v, b, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      bus.uart_rx = f[i];
      for (int c = 0; c < C; c++) begin
        rst = (i == rst_bit) && (c == C / 2);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    if (stop_v && rst_bit < 0) model_byte = b;
    if (rst_bit >= 0) model_byte = 8'h00;
  endtask
  task automatic idle(input int n);
    bus.uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int v0, f0;
    logic [7:0] b;
    bus.uart_rx = 1'b1;
    model_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_byte", bus.uart_byte, 8'h00);
    chk("rst_valid", bus.byte_valid, 1'b0);
    chk("rst_ferr", bus.frame_err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    idle(8);
    got.delete();
    send(8'h15, 1'b1, -1);
    chk("b15_lat", (last_valid_cyc - fall_cyc >= LAT - 1) && (last_valid_cyc - fall_cyc <= LAT + 1), 1);
    idle(C);
    chk("b15_byte", bus.uart_byte, 8'h15);
    chk("b15_nv", nv, 1);
    chk("b15_nf", nf, 0);
    chk("b15_busy", bus.busy, 1'b0);
    got.delete();
    send(8'h03, 1'b1, -1);
    chk("b2b_first", bus.uart_byte, 8'h03);
    send(8'h1A, 1'b1, -1);
    idle(C);
    chk("b2b_cnt", got.size(), 2);
    chk("b2b_0", got.size() > 0 ? got[0] : 8'hxx, 8'h03);
    chk("b2b_1", got.size() > 1 ? got[1] : 8'hxx, 8'h1A);
    chk("b2b_byte", bus.uart_byte, 8'h1A);
    got.delete();
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b, 1'b1, -1);
    end
    idle(C);
    chk("rnd_cnt", got.size(), exp_q.size());
    for (int k = 0; k < 6; k++) chk("rnd_byte", k < got.size() ? got[k] : 8'hxx, exp_q[k]);
    chk("rnd_last", bus.uart_byte, model_byte);
    v0 = nv;
    f0 = nf;
    send(8'hA5, 1'b0, -1);
    bus.uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("ferr_cnt", nf - f0, 1);
    chk("ferr_nv", nv - v0, 0);
    chk("ferr_byte", bus.uart_byte, model_byte);
    chk("ferr_busy_low", bus.busy, 1'b1);
    idle(6);
    chk("ferr_busy_hi", bus.busy, 1'b0);
    chk("ferr_once", nf - f0, 1);
    v0 = nv;
    f0 = nf;
    bcnt = 0;
    bus.uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(3 * C);
    chk("gl_nv", nv - v0, 0);
    chk("gl_nf", nf - f0, 0);
    chk("gl_byte", bus.uart_byte, model_byte);
    chk("gl_busy", (bcnt > 0) && (bcnt < C), 1);
    chk("gl_idle", bus.busy, 1'b0);
    v0 = nv;
    f0 = nf;
    send(8'hFF, 1'b1, 4);
    idle(C);
    chk("rst_mid_nv", nv - v0, 0);
    chk("rst_mid_nf", nf - f0, 0);
    chk("rst_mid_byte", bus.uart_byte, model_byte);
    send(8'h21, 1'b1, -1);
    idle(C);
    chk("post_rst_byte", bus.uart_byte, 8'h21);
    chk("post_rst_nv", nv - v0, 1);
    chk("never_both", both, 0);
    chk("never_double", dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
